// File: rtl/mcycle_ctrl_fsm.sv
// mcycle_ctrl_fsm: multicycle ARM control unit.
// Sequences the shared ALU/memory datapath through FETCH, DECODE, MEMADR,
// MEMREAD, MEMWRITE, MEMWB, EXECR, EXECI, ALUWB and BRANCH, and decodes the
// instruction fields into the per-state datapath strobes, including the ALU
// control decoder. Memory states wait on mem_ready.
//
// Ports:
//   clk, reset_n       clock, synchronous active-low reset
//   Op, Funct, Rd      instruction fields from the IR
//   mem_ready          memory completes the current access this cycle
//   mem_req            memory access requested
//   IRWrite, AdrSrc, ALUSrcA, ALUSrcB, ResultSrc, ALUControl, FlagW,
//   RegW, MemW, PCWrite, Branch        datapath controls
//   instr_done         pulse in an instruction's final cycle
//   illegal            pulse in DECODE for Op==11
//   cycle_cnt, instr_cnt               performance counters
//
// Configuration: define ARM_MCYC_PERF_EN to build the performance counters;
// otherwise cycle_cnt/instr_cnt are tied to 0.
module mcycle_ctrl_fsm #(
  parameter int unsigned PERF_W = 32
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [1:0]        Op,
  input  logic [5:0]        Funct,
  input  logic [3:0]        Rd,
  input  logic              mem_ready,
  output logic              mem_req,
  output logic              IRWrite,
  output logic              AdrSrc,
  output logic              ALUSrcA,
  output logic [1:0]        ALUSrcB,
  output logic [1:0]        ResultSrc,
  output logic [1:0]        ALUControl,
  output logic [1:0]        FlagW,
  output logic              RegW,
  output logic              MemW,
  output logic              PCWrite,
  output logic              Branch,
  output logic              instr_done,
  output logic              illegal,
  output logic [PERF_W-1:0] cycle_cnt,
  output logic [PERF_W-1:0] instr_cnt
);

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMREAD  = 4'd3,
    S_MEMWRITE = 4'd4,
    S_MEMWB    = 4'd5,
    S_EXECR    = 4'd6,
    S_EXECI    = 4'd7,
    S_ALUWB    = 4'd8,
    S_BRANCH   = 4'd9
  } state_e;

  state_e     state_q, state_d;
  logic [3:0] cmd;
  logic       s_bit;
  logic       cmp_tst;
  logic       rd_is_pc;
  logic [1:0] alu_dec;
  logic [1:0] flagw_dec;

  assign cmd      = Funct[4:1];
  assign s_bit    = Funct[0];
  assign cmp_tst  = (cmd == 4'b1010) || (cmd == 4'b1000);
  assign rd_is_pc = (Rd == 4'hF);

  // State register
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q <= S_FETCH;
    end else begin
      state_q <= state_d;
    end
  end

  // ALU control and flag-write decode, used only in the EXEC states
  always_comb begin
    alu_dec = 2'b00;
    case (cmd)
      4'b0100:          alu_dec = 2'b00;
      4'b0010, 4'b1010: alu_dec = 2'b01;
      4'b0000, 4'b1000: alu_dec = 2'b10;
      4'b1100:          alu_dec = 2'b11;
      default:          alu_dec = 2'b00;
    endcase
    // C/V only meaningful for arithmetic; compares always write both when S=1
    if (cmp_tst) begin
      flagw_dec = {s_bit, s_bit};
    end else begin
      flagw_dec = {s_bit, s_bit & ~alu_dec[1]};
    end
  end

  // Next-state and strobe decode; everything forced low while in reset
  always_comb begin
    state_d    = state_q;
    mem_req    = 1'b0;
    IRWrite    = 1'b0;
    AdrSrc     = 1'b0;
    ALUSrcA    = 1'b0;
    ALUSrcB    = 2'b00;
    ResultSrc  = 2'b00;
    ALUControl = 2'b00;
    FlagW      = 2'b00;
    RegW       = 1'b0;
    MemW       = 1'b0;
    PCWrite    = 1'b0;
    Branch     = 1'b0;
    instr_done = 1'b0;
    illegal    = 1'b0;

    case (state_q)
      S_FETCH: begin
        mem_req   = 1'b1;
        ALUSrcA   = 1'b1;
        ALUSrcB   = 2'b10;
        ResultSrc = 2'b10;
        IRWrite   = mem_ready;
        PCWrite   = mem_ready;
        if (mem_ready) state_d = S_DECODE;
      end
      S_DECODE: begin
        ALUSrcA   = 1'b1;
        ALUSrcB   = 2'b10;
        ResultSrc = 2'b10;
        case (Op)
          2'b01:   state_d = S_MEMADR;
          2'b00:   state_d = Funct[5] ? S_EXECI : S_EXECR;
          2'b10:   state_d = S_BRANCH;
          default: begin
            illegal    = 1'b1;
            instr_done = 1'b1;
            state_d    = S_FETCH;
          end
        endcase
      end
      S_MEMADR: begin
        ALUSrcB = 2'b01;
        state_d = Funct[0] ? S_MEMREAD : S_MEMWRITE;
      end
      S_MEMREAD: begin
        mem_req = 1'b1;
        AdrSrc  = 1'b1;
        if (mem_ready) state_d = S_MEMWB;
      end
      S_MEMWRITE: begin
        mem_req = 1'b1;
        AdrSrc  = 1'b1;
        MemW    = 1'b1;
        if (mem_ready) begin
          instr_done = 1'b1;
          state_d    = S_FETCH;
        end
      end
      S_MEMWB: begin
        ResultSrc  = 2'b01;
        RegW       = 1'b1;
        PCWrite    = rd_is_pc;
        instr_done = 1'b1;
        state_d    = S_FETCH;
      end
      S_EXECR, S_EXECI: begin
        ALUSrcB    = (state_q == S_EXECI) ? 2'b01 : 2'b00;
        ALUControl = alu_dec;
        FlagW      = flagw_dec;
        if (cmp_tst) begin
          instr_done = 1'b1;
          state_d    = S_FETCH;
        end else begin
          state_d = S_ALUWB;
        end
      end
      S_ALUWB: begin
        RegW       = 1'b1;
        PCWrite    = rd_is_pc;
        instr_done = 1'b1;
        state_d    = S_FETCH;
      end
      S_BRANCH: begin
        ALUSrcB    = 2'b01;
        ResultSrc  = 2'b10;
        Branch     = 1'b1;
        instr_done = 1'b1;
        state_d    = S_FETCH;
      end
      default: state_d = S_FETCH;
    endcase

    // Outputs are combinational, so reset must mask them in the same cycle
    if (!reset_n) begin
      mem_req    = 1'b0;
      IRWrite    = 1'b0;
      AdrSrc     = 1'b0;
      ALUSrcA    = 1'b0;
      ALUSrcB    = 2'b00;
      ResultSrc  = 2'b00;
      ALUControl = 2'b00;
      FlagW      = 2'b00;
      RegW       = 1'b0;
      MemW       = 1'b0;
      PCWrite    = 1'b0;
      Branch     = 1'b0;
      instr_done = 1'b0;
      illegal    = 1'b0;
    end
  end

`ifdef ARM_MCYC_PERF_EN
  logic [PERF_W-1:0] cycle_q, instr_q;

  // Free-running performance counters, wrap naturally
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      cycle_q <= '0;
      instr_q <= '0;
    end else begin
      cycle_q <= cycle_q + PERF_W'(1);
      if (IRWrite) instr_q <= instr_q + PERF_W'(1);
    end
  end

  assign cycle_cnt = reset_n ? cycle_q : '0;
  assign instr_cnt = reset_n ? instr_q : '0;
`else
  assign cycle_cnt = '0;
  assign instr_cnt = '0;
`endif

endmodule

// File: tb/tb_mcycle_ctrl_fsm.sv
// Testbench for mcycle_ctrl_fsm: per-instruction expected output traces,
// a directed vector table, a reset-during-store sequence, and random programs.
module tb_mcycle_ctrl_fsm;

  localparam int unsigned PERF_W = 32;

  logic              clk = 1'b0;
  logic              reset_n;
  logic [1:0]        Op;
  logic [5:0]        Funct;
  logic [3:0]        Rd;
  logic              mem_ready;
  logic              mem_req, IRWrite, AdrSrc, ALUSrcA;
  logic [1:0]        ALUSrcB, ResultSrc, ALUControl, FlagW;
  logic              RegW, MemW, PCWrite, Branch, instr_done, illegal;
  logic [PERF_W-1:0] cycle_cnt, instr_cnt;

  mcycle_ctrl_fsm #(.PERF_W(PERF_W)) dut (
    .clk(clk), .reset_n(reset_n), .Op(Op), .Funct(Funct), .Rd(Rd),
    .mem_ready(mem_ready), .mem_req(mem_req), .IRWrite(IRWrite),
    .AdrSrc(AdrSrc), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB),
    .ResultSrc(ResultSrc), .ALUControl(ALUControl), .FlagW(FlagW),
    .RegW(RegW), .MemW(MemW), .PCWrite(PCWrite), .Branch(Branch),
    .instr_done(instr_done), .illegal(illegal),
    .cycle_cnt(cycle_cnt), .instr_cnt(instr_cnt)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic       mem_req;
    logic       ir_write;
    logic       adr_src;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] result_src;
    logic [1:0] alu_control;
    logic [1:0] flag_w;
    logic       reg_w;
    logic       mem_w;
    logic       pc_write;
    logic       branch;
    logic       instr_done;
    logic       illegal;
  } out_t;

  typedef struct {
    logic [1:0] op;
    logic [5:0] funct;
    logic [3:0] rd;
    int         fw;
    int         mw;
    int         exp_cyc;
    bit         exp_regw;
    bit         exp_pcw;
    logic [1:0] exp_flagw;
  } vec_t;

  int   n_checks = 0;
  int   n_err    = 0;
  out_t exp_q[$];
  bit   rdy_q[$];
  logic [1:0] cur_op    = '0;
  logic [5:0] cur_funct = '0;
  logic [3:0] cur_rd    = '0;
  logic [PERF_W-1:0] m_cyc = '0;
  logic [PERF_W-1:0] m_ins = '0;

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s at %0t: got=%h expected=%h", name, $time, got, exp);
    end
  endtask

  function automatic out_t sample();
    out_t o;
    o = '{mem_req, IRWrite, AdrSrc, ALUSrcA, ALUSrcB, ResultSrc, ALUControl,
          FlagW, RegW, MemW, PCWrite, Branch, instr_done, illegal};
    return o;
  endfunction

  function automatic bit rnd_bit();
    return 1'($urandom_range(0, 1));
  endfunction

  // Expected per-cycle behaviour of one instruction, written from the ISA view
  task automatic build_trace(input logic [1:0] op, input logic [5:0] fn,
                             input logic [3:0] rd, input int fw, input int mw);
    out_t       o;
    logic [3:0] c;
    logic [1:0] alu;
    bit         cmp;
    exp_q.delete();
    rdy_q.delete();
    for (int i = 0; i <= fw; i++) begin
      o = '0;
      o.mem_req = 1'b1; o.alu_src_a = 1'b1; o.alu_src_b = 2'b10; o.result_src = 2'b10;
      o.ir_write = (i == fw); o.pc_write = (i == fw);
      exp_q.push_back(o); rdy_q.push_back(i == fw);
    end
    o = '0;
    o.alu_src_a = 1'b1; o.alu_src_b = 2'b10; o.result_src = 2'b10;
    if (op == 2'b11) begin o.illegal = 1'b1; o.instr_done = 1'b1; end
    exp_q.push_back(o); rdy_q.push_back(rnd_bit());
    case (op)
      2'b01: begin
        o = '0; o.alu_src_b = 2'b01;
        exp_q.push_back(o); rdy_q.push_back(rnd_bit());
        for (int i = 0; i <= mw; i++) begin
          o = '0; o.mem_req = 1'b1; o.adr_src = 1'b1; o.mem_w = !fn[0];
          o.instr_done = !fn[0] && (i == mw);
          exp_q.push_back(o); rdy_q.push_back(i == mw);
        end
        if (fn[0]) begin
          o = '0; o.result_src = 2'b01; o.reg_w = 1'b1; o.instr_done = 1'b1;
          o.pc_write = (rd == 4'd15);
          exp_q.push_back(o); rdy_q.push_back(rnd_bit());
        end
      end
      2'b00: begin
        c = fn[4:1];
        case (c)
          4'b0010, 4'b1010: alu = 2'b01;
          4'b0000, 4'b1000: alu = 2'b10;
          4'b1100:          alu = 2'b11;
          default:          alu = 2'b00;
        endcase
        cmp = (c == 4'b1010) || (c == 4'b1000);
        o = '0;
        o.alu_src_b   = fn[5] ? 2'b01 : 2'b00;
        o.alu_control = alu;
        o.flag_w[1]   = fn[0];
        o.flag_w[0]   = cmp ? fn[0] : (fn[0] && (alu == 2'b00 || alu == 2'b01));
        o.instr_done  = cmp;
        exp_q.push_back(o); rdy_q.push_back(rnd_bit());
        if (!cmp) begin
          o = '0; o.reg_w = 1'b1; o.instr_done = 1'b1; o.pc_write = (rd == 4'd15);
          exp_q.push_back(o); rdy_q.push_back(rnd_bit());
        end
      end
      2'b10: begin
        o = '0; o.alu_src_b = 2'b01; o.result_src = 2'b10; o.branch = 1'b1;
        o.instr_done = 1'b1;
        exp_q.push_back(o); rdy_q.push_back(rnd_bit());
      end
      default: ;
    endcase
  endtask

  task automatic apply_cycle(input bit rdy, input out_t exp, input bit rst, output out_t got);
    logic [PERF_W-1:0] ec, ei;
    @(negedge clk);
    reset_n = rst; mem_ready = rdy; Op = cur_op; Funct = cur_funct; Rd = cur_rd;
    #1;
    got = sample();
    chk("outputs", 64'(got), 64'(exp));
`ifdef ARM_MCYC_PERF_EN
    ec = rst ? m_cyc : '0;
    ei = rst ? m_ins : '0;
`else
    ec = '0;
    ei = '0;
`endif
    chk("cycle_cnt", 64'(cycle_cnt), 64'(ec));
    chk("instr_cnt", 64'(instr_cnt), 64'(ei));
    if (rst) begin
      m_cyc = m_cyc + 1'b1;
      if (exp.ir_write) m_ins = m_ins + 1'b1;
    end else begin
      m_cyc = '0;
      m_ins = '0;
    end
  endtask

  task automatic run_instr(input logic [1:0] op, input logic [5:0] fn, input logic [3:0] rd,
                           input int fw, input int mw, output int ncyc, output out_t last);
    out_t got;
    build_trace(op, fn, rd, fw, mw);
    cur_op = op; cur_funct = fn; cur_rd = rd;
    ncyc = -1;
    last = '0;
    for (int i = 0; i < exp_q.size(); i++) begin
      apply_cycle(rdy_q[i], exp_q[i], 1'b1, got);
      if (got.instr_done && ncyc < 0) begin
        ncyc = i + 1;
        last = got;
      end
    end
  endtask

  vec_t vecs[10];

  initial begin
    out_t got, last;
    int   ncyc;
    vecs[0] = '{2'b00, 6'b001000, 4'd1,  0, 0, 4, 1'b1, 1'b0, 2'b00}; // ADD
    vecs[1] = '{2'b01, 6'b011001, 4'd2,  0, 2, 7, 1'b1, 1'b0, 2'b00}; // LDR, 2 waits
    vecs[2] = '{2'b01, 6'b011000, 4'd3,  0, 3, 7, 1'b0, 1'b0, 2'b00}; // STR, 3 waits
    vecs[3] = '{2'b00, 6'b110101, 4'd0,  0, 0, 3, 1'b0, 1'b0, 2'b11}; // CMP imm
    vecs[4] = '{2'b00, 6'b011010, 4'd15, 0, 0, 4, 1'b1, 1'b1, 2'b00}; // MOV pc,r0
    vecs[5] = '{2'b11, 6'b000000, 4'd0,  0, 0, 2, 1'b0, 1'b0, 2'b00}; // illegal
    vecs[6] = '{2'b10, 6'b100000, 4'd0,  0, 0, 3, 1'b0, 1'b0, 2'b00}; // B
    vecs[7] = '{2'b01, 6'b011001, 4'd15, 1, 0, 6, 1'b1, 1'b1, 2'b00}; // LDR pc, fetch wait
    vecs[8] = '{2'b00, 6'b010001, 4'd0,  0, 0, 3, 1'b0, 1'b0, 2'b11}; // TST reg
    vecs[9] = '{2'b00, 6'b000001, 4'd4,  0, 0, 4, 1'b1, 1'b0, 2'b00}; // ANDS, ends in ALUWB

    reset_n = 1'b0; mem_ready = 1'b0; Op = '0; Funct = '0; Rd = '0;
    for (int i = 0; i < 3; i++) apply_cycle(1'b1, '0, 1'b0, got);

    for (int i = 0; i < 10; i++) begin
      run_instr(vecs[i].op, vecs[i].funct, vecs[i].rd, vecs[i].fw, vecs[i].mw, ncyc, last);
      chk($sformatf("latency[%0d]", i), 64'(ncyc), 64'(vecs[i].exp_cyc));
      chk($sformatf("last_regw[%0d]", i), 64'(last.reg_w), 64'(vecs[i].exp_regw));
      chk($sformatf("last_pcw[%0d]", i), 64'(last.pc_write), 64'(vecs[i].exp_pcw));
      chk($sformatf("last_flagw[%0d]", i), 64'(last.flag_w), 64'(vecs[i].exp_flagw));
    end

    // Reset while a store is stalled in MEMWRITE
    build_trace(2'b01, 6'b011000, 4'd3, 0, 3);
    cur_op = 2'b01; cur_funct = 6'b011000; cur_rd = 4'd3;
    for (int i = 0; i < 4; i++) apply_cycle(rdy_q[i], exp_q[i], 1'b1, got);
    chk("memw_before_reset", 64'(got.mem_w), 64'(1));
    apply_cycle(1'b0, '0, 1'b0, got);
    chk("memw_in_reset", 64'(got.mem_w), 64'(0));
    apply_cycle(1'b1, '0, 1'b0, got);
    run_instr(2'b00, 6'b001000, 4'd1, 0, 0, ncyc, last);
    chk("latency_after_reset", 64'(ncyc), 64'(4));

    // Random programs with random memory stalls
    for (int n = 0; n < 150; n++) begin
      run_instr(2'($urandom_range(0, 3)), 6'($urandom_range(0, 63)), 4'($urandom_range(0, 15)),
                int'($urandom_range(0, 2)), int'($urandom_range(0, 2)), ncyc, last);
      chk("random_done_seen", 64'(ncyc > 0), 64'(1));
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
